// File: rtl/instruction_fetch_controller_if.sv
// ============================================================================
// Module      : instruction_fetch_controller_if
// Description : Memory, redirect and decode-side signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface instruction_fetch_controller_if;
  logic        fetchEnable;
  logic [31:0] instructionAddress;
  logic [31:0] instruction;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        fetchValid;
  logic [31:0] fetchInstr;
  logic [31:0] fetchPc;
  logic        fetchReady;
  logic        halted;
  logic        fault;
  logic [31:0] faultPc;

  modport master (
    input  fetchEnable, instruction, redirectValid, redirectTarget, fetchReady,
    output instructionAddress, fetchValid, fetchInstr, fetchPc, halted, fault, faultPc
  );

  modport slave (
    output fetchEnable, instruction, redirectValid, redirectTarget, fetchReady,
    input  instructionAddress, fetchValid, fetchInstr, fetchPc, halted, fault, faultPc
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_controller.sv
// ============================================================================
// Module      : instruction_fetch_controller
// Description : PC sequencer with a 2-entry fetch queue, redirects, halt/fault.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 65536
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  instruction_fetch_controller_if.master bus
);

  localparam logic [32:0] c_LAST_WORD = 33'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic        r_ovf;
  logic [1:0]  r_count;
  logic [31:0] r_head_pc;
  logic [31:0] r_head_instr;
  logic [31:0] r_tail_pc;
  logic [31:0] r_tail_instr;
  logic        r_halted;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  logic        w_redir;
  logic        w_redir_legal;
  logic [32:0] w_pc_plus4;
  logic        w_pop;
  logic        w_slot;
  logic        w_fetch;
  logic        w_zero;
  logic        w_push;
  logic        w_ovf;
  logic        w_enter_fault;

  // PC+4 is evaluated one bit wider so the range check sees the true sum.
  assign w_pc_plus4    = {1'b0, r_pc} + 33'd4;
  assign w_redir       = bus.redirectValid && (r_state != S_FAULT);
  assign w_redir_legal = (bus.redirectTarget[1:0] == 2'b00) &&
                         ({1'b0, bus.redirectTarget} <= c_LAST_WORD);
  assign w_pop         = (r_count != 2'd0) && bus.fetchReady && !w_redir;
  assign w_slot        = (r_count != 2'd2) || w_pop;
  assign w_fetch       = (r_state == S_FETCH) && bus.fetchEnable && !w_redir && !r_ovf && w_slot;
  assign w_zero        = w_fetch && (bus.instruction == 32'h0);
  assign w_push        = w_fetch && !w_zero;
  assign w_ovf         = w_push && (w_pc_plus4 > c_LAST_WORD);

  always_comb begin
    w_next_state  = r_state;
    w_enter_fault = 1'b0;
    if (w_redir) begin
      if (!w_redir_legal) begin
        w_next_state  = S_FAULT;
        w_enter_fault = 1'b1;
      end else begin
        w_next_state = bus.fetchEnable ? S_FETCH : S_IDLE;
      end
    end else if (r_ovf) begin
      // The last legal word had one cycle to leave the queue before this.
      w_next_state  = S_FAULT;
      w_enter_fault = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.fetchEnable) w_next_state = S_FETCH;
        S_FETCH: begin
          if (w_zero)                 w_next_state = S_HALTED;
          else if (!bus.fetchEnable)  w_next_state = S_IDLE;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ovf        <= 1'b0;
      r_count      <= 2'd0;
      r_head_pc    <= 32'h0;
      r_head_instr <= 32'h0;
      r_tail_pc    <= 32'h0;
      r_tail_instr <= 32'h0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_pc   <= 32'h0;
    end else begin
      r_state <= w_next_state;
      r_ovf   <= w_ovf;

      if (w_redir && w_redir_legal) begin
        r_pc <= bus.redirectTarget;
      end else if (w_push) begin
        r_pc <= w_pc_plus4[31:0];
      end

      if (w_redir) begin
        r_halted <= 1'b0;
      end else if (w_zero) begin
        r_halted <= 1'b1;
      end

      if (w_enter_fault) begin
        r_fault    <= 1'b1;
        r_fault_pc <= w_redir ? bus.redirectTarget : r_pc;
      end

      // Flushing only clears occupancy so the head outputs keep their last values.
      if (w_redir || w_enter_fault) begin
        r_count <= 2'd0;
      end else begin
        case ({w_push, w_pop})
          2'b10: begin
            if (r_count == 2'd0) begin
              r_head_pc    <= r_pc;
              r_head_instr <= bus.instruction;
            end else begin
              r_tail_pc    <= r_pc;
              r_tail_instr <= bus.instruction;
            end
            r_count <= r_count + 2'd1;
          end
          2'b01: begin
            if (r_count == 2'd2) begin
              r_head_pc    <= r_tail_pc;
              r_head_instr <= r_tail_instr;
            end
            r_count <= r_count - 2'd1;
          end
          2'b11: begin
            if (r_count == 2'd1) begin
              r_head_pc    <= r_pc;
              r_head_instr <= bus.instruction;
            end else begin
              r_head_pc    <= r_tail_pc;
              r_head_instr <= r_tail_instr;
              r_tail_pc    <= r_pc;
              r_tail_instr <= bus.instruction;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.instructionAddress = r_pc;
  assign bus.fetchValid         = (r_count != 2'd0);
  assign bus.fetchInstr         = r_head_instr;
  assign bus.fetchPc            = r_head_pc;
  assign bus.halted             = r_halted;
  assign bus.fault              = r_fault;
  assign bus.faultPc            = r_fault_pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_controller.sv
// ============================================================================
// Module      : tb_instruction_fetch_controller
// Description : Directed self-checking bench for instruction_fetch_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instruction_fetch_controller;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   n_checks;
  int   n_pass;

  logic [31:0] prog [0:15];

  instruction_fetch_controller_if bus_a ();
  instruction_fetch_controller_if bus_b ();

  instruction_fetch_controller #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (65536)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  instruction_fetch_controller #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (16)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  assign bus_a.instruction = (bus_a.instructionAddress < 32'd64) ? prog[bus_a.instructionAddress[5:2]] : 32'h0;
  assign bus_b.instruction = (bus_b.instructionAddress < 32'd64) ? prog[bus_b.instructionAddress[5:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks = n_checks + 1;
    if (obs === exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    bus_a.fetchEnable   = 1'b0;
    bus_a.redirectValid = 1'b0;
    rst_n_a = 1'b0;
    tick();
    tick();
    rst_n_a = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    prog[0] = 32'h06400093; prog[1] = 32'h02000193;
    prog[2] = 32'h0011A023; prog[3] = 32'h0C800113;
    prog[4] = 32'h0021A423; prog[5] = 32'h0001A203;
    prog[6] = 32'h0081A283; prog[7] = 32'h00A28313;

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.fetchEnable    = 1'b0;
    bus_a.redirectValid  = 1'b0;
    bus_a.redirectTarget = 32'h0;
    bus_a.fetchReady     = 1'b1;
    bus_b.fetchEnable    = 1'b1;
    bus_b.redirectValid  = 1'b0;
    bus_b.redirectTarget = 32'h0;
    bus_b.fetchReady     = 1'b1;

    // Reset values
    tick();
    tick();
    chk("rst_valid", 32'(bus_a.fetchValid), 32'd0);
    chk("rst_instr", bus_a.fetchInstr, 32'h0);
    chk("rst_pc", bus_a.fetchPc, 32'h0);
    chk("rst_halted", 32'(bus_a.halted), 32'd0);
    chk("rst_fault", 32'(bus_a.fault), 32'd0);
    chk("rst_faultpc", bus_a.faultPc, 32'h0);
    chk("rst_addr", bus_a.instructionAddress, 32'h0);

    // Straight-line program run until the zero word
    rst_n_a = 1'b1;
    bus_a.fetchEnable = 1'b1;
    tick();
    chk("idle_to_fetch_valid", 32'(bus_a.fetchValid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("seq_valid_%0d", i), 32'(bus_a.fetchValid), 32'd1);
      chk($sformatf("seq_pc_%0d", i), bus_a.fetchPc, 32'(4 * i));
      chk($sformatf("seq_instr_%0d", i), bus_a.fetchInstr, prog[i]);
    end
    tick();
    chk("halt_halted", 32'(bus_a.halted), 32'd1);
    chk("halt_valid", 32'(bus_a.fetchValid), 32'd0);
    chk("halt_addr", bus_a.instructionAddress, 32'h20);
    chk("halt_hold_pc", bus_a.fetchPc, 32'h1C);
    tick();
    chk("halt_stays", 32'(bus_a.halted), 32'd1);

    // Legal redirect out of HALTED resumes fetching
    bus_a.redirectValid  = 1'b1;
    bus_a.redirectTarget = 32'h14;
    tick();
    bus_a.redirectValid = 1'b0;
    chk("hredir_halted", 32'(bus_a.halted), 32'd0);
    chk("hredir_valid", 32'(bus_a.fetchValid), 32'd0);
    chk("hredir_addr", bus_a.instructionAddress, 32'h14);
    tick();
    chk("hredir_head_pc", bus_a.fetchPc, 32'h14);
    chk("hredir_head_instr", bus_a.fetchInstr, 32'h0001A203);

    // Backpressure: four stalled cycles after start
    reset_a();
    bus_a.fetchReady  = 1'b0;
    bus_a.fetchEnable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_valid", 32'(bus_a.fetchValid), 32'd1);
    chk("bp_head_pc", bus_a.fetchPc, 32'h0);
    chk("bp_head_instr", bus_a.fetchInstr, prog[0]);
    chk("bp_addr_stall", bus_a.instructionAddress, 32'h8);
    bus_a.fetchReady = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("bp_rel_pc_%0d", k), bus_a.fetchPc, 32'(4 * k));
      chk($sformatf("bp_rel_instr_%0d", k), bus_a.fetchInstr, prog[k]);
    end

    // Redirect while the queue is full
    bus_a.redirectValid  = 1'b1;
    bus_a.redirectTarget = 32'h14;
    tick();
    bus_a.redirectValid = 1'b0;
    chk("redir_flush_valid", 32'(bus_a.fetchValid), 32'd0);
    chk("redir_addr", bus_a.instructionAddress, 32'h14);
    tick();
    chk("redir_valid", 32'(bus_a.fetchValid), 32'd1);
    chk("redir_pc", bus_a.fetchPc, 32'h14);
    chk("redir_instr", bus_a.fetchInstr, 32'h0001A203);

    // Misaligned redirect latches a fault; later redirects are ignored
    bus_a.redirectValid  = 1'b1;
    bus_a.redirectTarget = 32'h6;
    tick();
    chk("ill_fault", 32'(bus_a.fault), 32'd1);
    chk("ill_faultpc", bus_a.faultPc, 32'h6);
    chk("ill_valid", 32'(bus_a.fetchValid), 32'd0);
    chk("ill_addr_hold", bus_a.instructionAddress, 32'h18);
    bus_a.redirectTarget = 32'h0;
    tick();
    bus_a.redirectValid = 1'b0;
    tick();
    chk("fault_sticky", 32'(bus_a.fault), 32'd1);
    chk("fault_addr_hold", bus_a.instructionAddress, 32'h18);
    chk("fault_faultpc_hold", bus_a.faultPc, 32'h6);
    chk("fault_no_valid", 32'(bus_a.fetchValid), 32'd0);

    // Asynchronous reset with two entries queued
    reset_a();
    bus_a.fetchReady  = 1'b0;
    bus_a.fetchEnable = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_arst_valid", 32'(bus_a.fetchValid), 32'd1);
    chk("pre_arst_addr", bus_a.instructionAddress, 32'h8);
    #2;
    rst_n_a = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_a.fetchValid), 32'd0);
    chk("arst_instr", bus_a.fetchInstr, 32'h0);
    chk("arst_pc", bus_a.fetchPc, 32'h0);
    chk("arst_addr", bus_a.instructionAddress, 32'h0);
    chk("arst_fault", 32'(bus_a.fault), 32'd0);
    bus_a.fetchReady = 1'b1;
    tick();
    rst_n_a = 1'b1;
    tick();
    tick();
    chk("restart_pc", bus_a.fetchPc, 32'h0);
    chk("restart_instr", bus_a.fetchInstr, prog[0]);

    // Redirect beyond the last legal word
    bus_a.redirectValid  = 1'b1;
    bus_a.redirectTarget = 32'h0001_0000;
    tick();
    bus_a.redirectValid = 1'b0;
    chk("oor_fault", 32'(bus_a.fault), 32'd1);
    chk("oor_faultpc", bus_a.faultPc, 32'h0001_0000);
    chk("oor_valid", 32'(bus_a.fetchValid), 32'd0);

    // Sequential overflow on a 16-byte memory
    rst_n_b = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ovf_pc_%0d", i), bus_b.fetchPc, 32'(4 * i));
      chk($sformatf("ovf_instr_%0d", i), bus_b.fetchInstr, prog[i]);
      chk($sformatf("ovf_nofault_%0d", i), 32'(bus_b.fault), 32'd0);
    end
    tick();
    chk("ovf_fault", 32'(bus_b.fault), 32'd1);
    chk("ovf_faultpc", bus_b.faultPc, 32'h10);
    chk("ovf_valid", 32'(bus_b.fetchValid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
Sequences instruction fetch from the byte-addressed, combinational-read instruction memory. Owns the PC and drives the memory address. Buffers fetched words in a 2-entry queue toward decode with a valid/ready handshake. Handles redirects (branch/jump), end-of-program detection (all-zero word) and fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
MEM_BYTES, 65536, instruction memory size in bytes; legal word addresses are 0 to MEM_BYTES-4.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
fetchEnable  input  1  run request; while low, no new fetches are issued.
instructionAddress  output  32  byte address to instruction memory; always equals the PC register.
instruction  input  32  little-endian word returned combinationally by memory for instructionAddress.
redirectValid  input  1  one-cycle pulse: load redirectTarget into PC.
redirectTarget  input  32  new PC.
fetchValid  output  1  queue head is valid.
fetchInstr  output  32  queue head instruction.
fetchPc  output  32  queue head PC.
fetchReady  input  1  decode accepts the head when fetchValid & fetchReady.
halted  output  1  an all-zero word was fetched.
fault  output  1  fetch fault is latched.
faultPc  output  32  offending address.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; state IDLE; queue empty.
  - fetchValid=0, fetchInstr=0, fetchPc=0, halted=0, fault=0, faultPc=0.
  - Release is synchronous to clk.
- States:
  - IDLE: not fetching. Go to FETCH when fetchEnable=1.
  - FETCH: issue fetches. Go to IDLE when fetchEnable=0.
  - HALTED: entered on a zero word. Exit to FETCH on a legal redirect when fetchEnable=1, else to IDLE.
  - FAULT: terminal; exit only by reset.
- Enqueue (FETCH only): at a clock edge, if the queue has space, or is full and a pop happens the same edge, then:
  - push {PC, instruction};
  - PC <= PC+4.
- Zero word: instruction==32'h0 in FETCH is not enqueued.
  - PC holds; state goes to HALTED; halted=1.
  - Existing queue entries still drain.
- Sequential overflow: if PC+4 > MEM_BYTES-4 after a push, the next cycle enters FAULT with faultPc=PC+4. The last legal word is still enqueued.
- Queue:
  - 2-entry FIFO; head drives the fetch* outputs; pop on fetchValid & fetchReady.
  - Simultaneous push and pop when full is allowed; occupancy stays 2.
  - Empty queue: fetchValid=0; fetchInstr and fetchPc hold their last values.
- Throughput: 1 instruction per cycle sustained with fetchReady=1.
- Latency: the PC is presented in cycle N, enqueued at the end of N, and fetchValid=1 in N+1.
- Redirect (highest priority, any state except FAULT):
  - Queue flushed; no push and no pop that cycle, even if fetchReady=1.
  - PC <= redirectTarget; halted cleared.
  - The target is fetched in the next cycle; first fetchValid is 2 cycles after the redirect pulse.
- Illegal redirect: redirectTarget[1:0]!=0 or redirectTarget > MEM_BYTES-4.
  - Queue flushed; FAULT entered; fault=1; faultPc=redirectTarget; PC unchanged.
- FAULT:
  - fetchValid=0 and the queue is empty.
  - instructionAddress holds the PC; redirects are ignored.
- fetchEnable=0:
  - Queue keeps draining.
  - A redirect in IDLE updates the PC and flushes the queue.
- Reset mid-operation: immediate return to reset values, including in-flight queue contents.
- PC arithmetic: 32-bit unsigned. The overflow check runs before wrap, so the PC never wraps.

Test Plan:
- Reset, fetchEnable=1, fetchReady=1, memory program from 0x0 → fetchInstr sequence:
  - 0x06400093, 0x02000193, 0x0011A023, 0x0C800113, 0x0021A423, 0x0001A203, 0x0081A283, 0x00A28313, one per cycle, fetchPc 0x0..0x1C;
  - then halted=1, PC=0x20, fetchValid=0.
- Backpressure: fetchReady=0 for 4 cycles after start → queue holds PCs 0x0 and 0x4; instructionAddress stalls at 0x8; on release, order is preserved with no duplicates or drops.
- Redirect to 0x14 while queue full → queue flushed that cycle; fetchValid=0 for 1 cycle; next head is pc 0x14, instr 0x0001A203.
- Redirect to 0x6 → fault=1, faultPc=0x6, fetchValid=0; a later redirect to 0x0 has no effect until reset.
- MEM_BYTES=16, fetch from 0 → pcs 0x0..0xC delivered, then fault=1, faultPc=0x10.
- Assert rst_n=0 mid-stream with 2 entries queued → all outputs 0 asynchronously; after release, the fetch restarts at RESET_PC.
